// File: rtl/rx_frame_decoder.sv
// Frame delineation and validation for the received byte stream: assembles
// {header, payload} command words, hands them off over valid/ready, and keeps saturating status counters.
module rx_frame_decoder #(
    parameter logic [3:0] HDR_NIBBLE    = 4'hF,
    parameter int         PAYLOAD_BYTES = 3,
    parameter int         CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   Q,
    input  logic                         nRx,
    output logic [8+8*PAYLOAD_BYTES-1:0] cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             hdr_err_cnt,
    output logic [CNT_W-1:0]             short_err_cnt,
    output logic [CNT_W-1:0]             long_err_cnt,
    output logic [CNT_W-1:0]             ovf_cnt
);

    localparam int DATA_W = 8 + 8*PAYLOAD_BYTES;
    localparam int BC_W   = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK_END, DROP} state_t;

    state_t            r_state;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [DATA_W-1:0] r_asm;
    logic [DATA_W-1:0] r_cmd_data;
    logic              r_cmd_valid;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_hdr_err_cnt;
    logic [CNT_W-1:0]  r_short_err_cnt;
    logic [CNT_W-1:0]  r_long_err_cnt;
    logic [CNT_W-1:0]  r_ovf_cnt;

    logic w_commit;
    logic w_load;

    // A commit may only replace the held word if the slot is empty or being drained this cycle.
    assign w_commit = (r_state == CHECK_END) && nRx;
    assign w_load   = w_commit && (!r_cmd_valid || cmd_ready);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: every register here is updated with <= so all state advances from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_byte_cnt      <= '0;
            r_asm           <= '0;
            r_cmd_data      <= '0;
            r_cmd_valid     <= 1'b0;
            r_frame_cnt     <= '0;
            r_hdr_err_cnt   <= '0;
            r_short_err_cnt <= '0;
            r_long_err_cnt  <= '0;
            r_ovf_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!nRx) begin
                        if (Q[7:4] == HDR_NIBBLE) begin
                            r_asm      <= {{(DATA_W-8){1'b0}}, Q};
                            r_byte_cnt <= '0;
                            r_state    <= PAYLOAD;
                        end else begin
                            r_hdr_err_cnt <= sat_inc(r_hdr_err_cnt);
                            r_state       <= DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!nRx) begin
                        r_asm      <= {r_asm[DATA_W-9:0], Q};
                        r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        if (r_byte_cnt == LAST_IDX) begin
                            r_state <= CHECK_END;
                        end
                    end else begin
                        r_short_err_cnt <= sat_inc(r_short_err_cnt);
                        r_state         <= IDLE;
                    end
                end
                CHECK_END: begin
                    if (nRx) begin
                        r_frame_cnt <= sat_inc(r_frame_cnt);
                        r_state     <= IDLE;
                    end else begin
                        r_long_err_cnt <= sat_inc(r_long_err_cnt);
                        r_state        <= DROP;
                    end
                end
                DROP: begin
                    if (nRx) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                r_cmd_data  <= r_asm;
                r_cmd_valid <= 1'b1;
            end else if (w_commit) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_data      = r_cmd_data;
    assign cmd_valid     = r_cmd_valid;
    assign frame_cnt     = r_frame_cnt;
    assign hdr_err_cnt   = r_hdr_err_cnt;
    assign short_err_cnt = r_short_err_cnt;
    assign long_err_cnt  = r_long_err_cnt;
    assign ovf_cnt       = r_ovf_cnt;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: a cycle vector table for the handshake path,
// then hand-written sequences for error frames, overflow, saturation and mid-frame reset.
module tb_rx_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  Q;
    logic        nRx;
    logic        cmd_ready;

    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic [15:0] frame_cnt, hdr_err_cnt, short_err_cnt, long_err_cnt, ovf_cnt;

    // Second instance with 2-bit counters so saturation is reachable in a few frames.
    logic [31:0] s_cmd_data;
    logic        s_cmd_valid;
    logic [1:0]  s_frame_cnt, s_hdr_err_cnt, s_short_err_cnt, s_long_err_cnt, s_ovf_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rx_frame_decoder #(.HDR_NIBBLE(4'hF), .PAYLOAD_BYTES(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Q(Q), .nRx(nRx),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .frame_cnt(frame_cnt), .hdr_err_cnt(hdr_err_cnt), .short_err_cnt(short_err_cnt),
        .long_err_cnt(long_err_cnt), .ovf_cnt(ovf_cnt)
    );

    rx_frame_decoder #(.HDR_NIBBLE(4'hF), .PAYLOAD_BYTES(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .Q(Q), .nRx(nRx),
        .cmd_data(s_cmd_data), .cmd_valid(s_cmd_valid), .cmd_ready(cmd_ready),
        .frame_cnt(s_frame_cnt), .hdr_err_cnt(s_hdr_err_cnt), .short_err_cnt(s_short_err_cnt),
        .long_err_cnt(s_long_err_cnt), .ovf_cnt(s_ovf_cnt)
    );

    typedef struct {
        logic        nrx;
        logic [7:0]  q;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [15:0] exp_frames;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic add(input logic nrx, input logic [7:0] q, input logic rdy,
                       input logic ev, input logic [31:0] ed, input logic [15:0] ef);
        vec_t v;
        v.nrx = nrx; v.q = q; v.rdy = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_frames = ef;
        vecs.push_back(v);
    endtask

    // Drive one cycle of input (Q is X while nRx is high) and settle just after the edge.
    task automatic step(input logic nrx, input logic [7:0] q, input logic rdy);
        nRx       = nrx;
        Q         = nrx ? 8'hxx : q;
        cmd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int n, input logic rdy);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        for (int i = 0; i < n; i++) step(1'b0, bytes[i], rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  {63'd0, cmd_valid}, 64'd0);
        check({tag, ".data"},   {32'd0, cmd_data}, 64'd0);
        check({tag, ".counts"}, {frame_cnt, hdr_err_cnt, short_err_cnt, long_err_cnt}, 64'd0);
        check({tag, ".ovf"},    {48'd0, ovf_cnt}, 64'd0);
        check({tag, ".sat"},    {54'd0, s_cmd_valid, s_frame_cnt, s_hdr_err_cnt,
                                 s_short_err_cnt, s_long_err_cnt, s_ovf_cnt}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; nRx = 1'b1; Q = 8'h00; cmd_ready = 1'b0;
        #12;
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame with consumer ready: one-cycle pulse one cycle after the last byte.
        add(0, 8'hF0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 1, 0, 32'h0, 0);
        add(1, 8'h00, 1, 1, 32'hF0000000, 1);
        add(1, 8'h00, 1, 0, 32'hF0000000, 1);
        // Good frame with consumer stalled for 10 cycles, then drained.
        add(0, 8'hF5, 0, 0, 32'hF0000000, 1);
        add(0, 8'h12, 0, 0, 32'hF0000000, 1);
        add(0, 8'h34, 0, 0, 32'hF0000000, 1);
        add(0, 8'h56, 0, 0, 32'hF0000000, 1);
        for (int i = 0; i < 10; i++) add(1, 8'h00, 0, 1, 32'hF5123456, 2);
        add(1, 8'h00, 1, 0, 32'hF5123456, 2);

        foreach (vecs[i]) begin
            step(vecs[i].nrx, vecs[i].q, vecs[i].rdy);
            check($sformatf("vec%0d.valid", i),  {63'd0, cmd_valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d.data", i),   {32'd0, cmd_data},  {32'd0, vecs[i].exp_data});
            check($sformatf("vec%0d.frames", i), {48'd0, frame_cnt}, {48'd0, vecs[i].exp_frames});
        end

        // Bad header followed by payload-looking bytes.
        send(8'hA0, 8'h01, 8'h02, 8'h03, 4, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        check("hdr.valid", {63'd0, cmd_valid}, 64'd0);
        check("hdr.cnt",   {48'd0, hdr_err_cnt}, 64'd1);

        // Short frame, then a frame one byte too long.
        send(8'hF0, 8'h11, 8'h00, 8'h00, 2, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        check("short.cnt", {48'd0, short_err_cnt}, 64'd1);
        send(8'hF0, 8'h01, 8'h02, 8'h03, 4, 1'b1);
        step(1'b0, 8'h04, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        check("long.cnt",    {48'd0, long_err_cnt}, 64'd1);
        check("long.valid",  {63'd0, cmd_valid}, 64'd0);
        check("long.frames", {48'd0, frame_cnt}, 64'd2);
        check("err.hdr_unchanged", {48'd0, hdr_err_cnt}, 64'd1);

        // Back-to-back good frames, one idle cycle apart, consumer stalled.
        send(8'hF1, 8'hAA, 8'hBB, 8'hCC, 4, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        send(8'hF2, 8'h11, 8'h22, 8'h33, 4, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("b2b.valid",  {63'd0, cmd_valid}, 64'd1);
        check("b2b.data",   {32'd0, cmd_data}, {32'd0, 32'hF1AABBCC});
        check("b2b.ovf",    {48'd0, ovf_cnt}, 64'd1);
        check("b2b.frames", {48'd0, frame_cnt}, 64'd4);

        // Three more short frames: 4 total, 2-bit counter must stick at 3.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'hF0, 1'b0);
            step(1'b1, 8'h00, 1'b0);
        end
        check("sat.short_small", {62'd0, s_short_err_cnt}, 64'd3);
        check("sat.short_wide",  {48'd0, short_err_cnt}, 64'd4);
        check("sat.frames_small", {62'd0, s_frame_cnt}, 64'd3);

        // Mid-frame reset while a word is still held.
        send(8'hF7, 8'h01, 8'h00, 8'h00, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        #2 rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b1);
        send(8'hF3, 8'h01, 8'h02, 8'h03, 4, 1'b1);
        check("post.valid_early", {63'd0, cmd_valid}, 64'd0);
        step(1'b1, 8'h00, 1'b1);
        check("post.valid",  {63'd0, cmd_valid}, 64'd1);
        check("post.data",   {32'd0, cmd_data}, {32'd0, 32'hF3010203});
        check("post.frames", {48'd0, frame_cnt}, 64'd1);
        check("post.errs",   {short_err_cnt, long_err_cnt, hdr_err_cnt, ovf_cnt}, 64'd0);
        step(1'b1, 8'h00, 1'b1);
        check("post.drained", {63'd0, cmd_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_decoder.md
Name: rx_frame_decoder

Overview:
- Downstream of the sync receive front end, in the user_hs_clk domain.
- Consumes the raw byte stream (Q, nRx) and delineates frames; a frame is a header byte followed by PAYLOAD_BYTES payload bytes while nRx is held low.
- Validates the frame and presents one command word to the command dispatcher over a valid/ready handshake.
- Keeps saturating error and frame counters for the status register block.

Parameters:
- HDR_NIBBLE, 4'hF, required value of header bits [7:4].
- PAYLOAD_BYTES, 3, payload bytes per frame. Legal range 1..3.
- CNT_W, 16, width of every status counter.

Ports:
- clk  in  1  user_hs_clk-domain clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Q  in  8  received byte; sampled only when nRx is low.
- nRx  in  1  active-low byte valid; low for consecutive cycles spans one frame.
- cmd_data  out  8+8*PAYLOAD_BYTES  {header, payload bytes}; first payload byte is the most significant.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts when cmd_valid && cmd_ready.
- frame_cnt  out  CNT_W  good frames committed.
- hdr_err_cnt  out  CNT_W  frames rejected for bad header.
- short_err_cnt  out  CNT_W  frames ended before full payload.
- long_err_cnt  out  CNT_W  frames with extra bytes.
- ovf_cnt  out  CNT_W  good frames lost because the output was still occupied.

Behaviour:
- Reset (async assert, sync release): all outputs 0. FSM goes to IDLE, byte counter 0, assembly register 0.
- FSM states: IDLE, PAYLOAD, CHECK_END, DROP.
- IDLE, nRx low, Q[7:4]==HDR_NIBBLE: store Q as header, byte count=0, go to PAYLOAD.
- IDLE, nRx low, Q[7:4]!=HDR_NIBBLE: hdr_err_cnt++, go to DROP.
- IDLE, nRx high: stay in IDLE.
- PAYLOAD, nRx low: shift Q into assembly, count++. When count reaches PAYLOAD_BYTES, go to CHECK_END.
- PAYLOAD, nRx high: short_err_cnt++, discard, go to IDLE.
- CHECK_END, nRx high: commit the frame, frame_cnt++, go to IDLE. The new nRx-low edge is not examined in this cycle.
- CHECK_END, nRx low: long_err_cnt++ (once per frame), go to DROP.
- DROP: stay while nRx is low; go to IDLE on the first cycle nRx is high. Nothing else is counted while in DROP.
- Frames are separated by at least one nRx-high cycle. A header arriving the cycle after CHECK_END is handled from IDLE.
- Commit and output register:
  - On commit, if cmd_valid==0, or cmd_valid && cmd_ready in the same cycle: load cmd_data and set cmd_valid=1 on the next edge.
  - Otherwise hold the old word, drop the new one, ovf_cnt++. frame_cnt still increments.
  - cmd_valid && cmd_ready with no commit: cmd_valid=0 next edge. cmd_data holds its last value.
  - cmd_data stays stable while cmd_valid && !cmd_ready.
- Latency: cmd_valid rises on the clock edge that samples the first nRx-high cycle after the last payload byte (1 cycle after the last byte).
- Counters are independent CNT_W-bit registers that saturate at all-ones; they never wrap.
- Q is ignored whenever nRx is high. X on Q while nRx is high must not propagate.
- rst_n asserted mid-frame: immediate return to the reset state, partial frame lost, no counter increments.

Test Plan:
- F0,00,00,00 on 4 consecutive nRx-low cycles, then nRx high, cmd_ready=1 -> exactly one cmd_valid pulse with cmd_data=32'hF0000000, 1 cycle after last byte; frame_cnt=1.
- F5,12,34,56 then nRx high with cmd_ready=0 for 10 cycles -> cmd_data=32'hF5123456 and cmd_valid held stable for all 10 cycles; cleared 1 cycle after cmd_ready=1.
- Header A0 followed by 3 bytes -> no cmd_valid; hdr_err_cnt=1.
- F0,11 then nRx high -> short_err_cnt=1; then 5-byte frame F0,01,02,03,04 -> long_err_cnt=1, no command.
- Back-to-back good frames (one idle cycle between) with cmd_ready=0 -> first word held, ovf_cnt=1, frame_cnt=2.
- Force short_err_cnt to 16'hFFFF, inject a short frame -> stays 16'hFFFF. Assert rst_n low after 2 bytes -> all outputs 0; a following good frame decodes correctly.
